gray_sync_decoder: RTL and testbench
====================================

# gray_sync_decoder

Receive-side companion of the free-running Gray counter. It takes a Gray-coded count produced in another clock domain and passes it through a reset-initialised synchronizer chain. It then decodes the value to binary and reports each advance as a strobe plus a step count. It sits at the consumer end of every Gray-pointer crossing in the design (FIFO pointers, timestamp/sequence counters).

## Interface
- SIZE, 16: count width in bits; must equal the transmitter's width; legal 2..128.
- SYNC_STAGES, 2: synchronizer flops on gray_in; legal 2..4.
- clk  input  1  receive-domain clock.
- nreset  input  1  reset: nreset, asynchronous, active-low; clock clk.
- init_count_bin  input  SIZE  binary reset count; must match the transmitter's init value; quasi-static, sampled only while nreset is low.
- gray_in  input  SIZE  Gray count from the foreign domain; asynchronous to clk.
- bin_q  output  SIZE  decoded binary count, registered.
- adv  output  1  one-cycle strobe: bin_q changed on this edge.
- delta  output  SIZE  bin_q(new) - bin_q(old), modulo 2^SIZE; 0 when adv=0.
- err  output  1  sticky coherence error; exists only with the macro (see Configuration).

## Operation
- Synchronizer: sync[0] <= gray_in; sync[k] <= sync[k-1]. The last stage is gray_s.
- Every sync stage resets to gray(init_count_bin) = (init_count_bin>>1)^init_count_bin. No spurious advance is reported after reset.
- Decoder (combinational): b[SIZE-1] = g[SIZE-1]; b[i] = b[i+1]^g[i]. Equivalently, b[i] is the XOR of g[SIZE-1:i].
- Output register, updated on every clk edge out of reset:
  - bin_q <= decode(gray_s)
  - delta <= decode(gray_s) - bin_q, truncated to SIZE bits
  - adv <= (decode(gray_s) != bin_q)
- Wrap-around: 2^SIZE-1 -> 0 (Gray 100..0 -> 000..0) gives adv=1, delta=1. No overflow flag.
- Multi-step advance between samples is legal as long as gray_in is coherent: delta reports the full step, e.g. 3.
- Hold (gray_in static): adv=0, delta=0, bin_q stable.
- Backwards step (transmitter reset or reload): delta wraps modulo 2^SIZE, e.g. 5 -> 3 gives delta=2^SIZE-2. adv=1.
- Reset values: bin_q=init_count_bin, adv=0, delta=0, err=0, every sync stage as above.
- Reset mid-operation: all state returns to the reset values asynchronously. The first post-reset edge compares against init_count_bin.

## Timing
- Latency: a gray_in value present at edge N appears in gray_s after edge N+SYNC_STAGES-1. It is reflected on bin_q, adv and delta after edge N+SYNC_STAGES, i.e. SYNC_STAGES+1 edges counting the capture edge.
- Throughput: one decoded sample per clk.
- adv is high for exactly one cycle per change of gray_s. Consecutive changes give consecutive adv pulses.
- Path constraint: the gray_in -> sync[0] path is a CDC path. Constrain it with max-delay equal to one transmitter period; no false path.

## Configuration
- GRAY_SYNC_ERRCHK_EN defined:
  - Adds a register prev_s holding the previous gray_s, reset to gray(init_count_bin).
  - If popcount(gray_s ^ prev_s) > 1, err is set on the next edge and stays set until nreset.
  - bin_q, adv and delta still update normally.
  - Adds one comparison stage in parallel with decode; latency is unchanged.
- GRAY_SYNC_ERRCHK_EN undefined: the err port and prev_s are absent, with zero area.

## Structure
- Shared package gray_pkg holds:
  - functions bin2gray(SIZE) and gray2bin(SIZE)
  - function popcount_gt1, for the error check
  - localparam GRAY_MAX_SIZE=128, shared with the transmitter counter
- One sub-module, gray_sync_chain: a parameterised SYNC_STAGES x SIZE flop chain with a per-bit reset value. It is reused by other CDC blocks.
- Decode, delta and adv live in the top module.

## Test plan
Benches use SIZE=4, SYNC_STAGES=2.
- Reset with init_count_bin=5, gray_in=gray(5)=0111, then release -> bin_q=5, adv=0, delta=0 for every following cycle.
- gray_in driven from a transmitter counting 5,6,7,... at one step per 3 clk -> each new value appears on bin_q 3 edges after the gray_in change, with adv=1 and delta=1 once per step.
- Transmitter counts 14,15,0,1 -> bin_q shows 15->0 with adv=1, delta=1 (wrap, no error).
- gray_in jumps coherently from gray(2) to gray(5) = 0011->0111 -> bin_q=5, delta=3, adv=1 for one cycle. With GRAY_SYNC_ERRCHK_EN, err stays 0, since only one bit changed.
- With GRAY_SYNC_ERRCHK_EN, gray_in 0000->0011 (two bits change) -> err=1 three edges later and it stays 1. nreset pulse -> err=0.
- Assert nreset while adv=1 mid-stream -> adv=0, delta=0, bin_q=init_count_bin immediately, and no adv on the first edge after release.

Source files
------------

// File: rtl/gray_pkg.sv
// Gray/binary helpers shared by the Gray counter transmitter and its receive-side decoders.
// Functions work on GRAY_MAX_SIZE-wide words; callers zero-extend on entry and truncate on return.
package gray_pkg;

  localparam int GRAY_MAX_SIZE = 128;

  typedef logic [GRAY_MAX_SIZE-1:0] gray_word_t;

  function automatic gray_word_t bin2gray(input gray_word_t b);
    return (b >> 1) ^ b;
  endfunction

  // Zero upper bits from extension leave the running XOR untouched.
  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b[GRAY_MAX_SIZE-1] = g[GRAY_MAX_SIZE-1];
    for (int i = GRAY_MAX_SIZE-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // More than one bit set iff clearing the lowest set bit leaves something behind.
  function automatic logic popcount_gt1(input gray_word_t x);
    return (x & (x - gray_word_t'(1))) != '0;
  endfunction

endpackage

// File: rtl/gray_sync_chain.sv
// STAGES x WIDTH synchronizer flop chain with a per-bit reset value; q is the last stage.
// Latency STAGES edges; no backpressure, samples d on every clk.
module gray_sync_chain #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int k = 0; k < STAGES; k++) begin
        stage[k] <= rst_val;
      end
    end else begin
      stage[0] <= d;
      for (int k = 1; k < STAGES; k++) begin
        stage[k] <= stage[k-1];
      end
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/gray_sync_decoder.sv
// Synchronizes a foreign-domain Gray count, decodes it to binary and reports advances (adv/delta); optional err via GRAY_SYNC_ERRCHK_EN.
// Latency SYNC_STAGES+1 edges from gray_in to bin_q/adv/delta; no backpressure, one sample per clk.
module gray_sync_decoder
  import gray_pkg::*;
#(
  parameter int SIZE        = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [SIZE-1:0] init_count_bin,
  input  logic [SIZE-1:0] gray_in,
  output logic [SIZE-1:0] bin_q,
  output logic            adv,
  output logic [SIZE-1:0] delta
`ifdef GRAY_SYNC_ERRCHK_EN
  ,
  output logic            err
`endif
);

  logic [SIZE-1:0] init_gray;
  logic [SIZE-1:0] gray_s;
  logic [SIZE-1:0] bin_dec;

  // init_count_bin is quasi-static, so using it as an async reset value is safe.
  assign init_gray = SIZE'(bin2gray(gray_word_t'(init_count_bin)));

  gray_sync_chain #(
    .WIDTH  (SIZE),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .nreset  (nreset),
    .rst_val (init_gray),
    .d       (gray_in),
    .q       (gray_s)
  );

  assign bin_dec = SIZE'(gray2bin(gray_word_t'(gray_s)));

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      bin_q <= init_count_bin;
      adv   <= 1'b0;
      delta <= '0;
    end else begin
      bin_q <= bin_dec;
      delta <= bin_dec - bin_q;
      adv   <= (bin_dec != bin_q);
    end
  end

`ifdef GRAY_SYNC_ERRCHK_EN
  logic [SIZE-1:0] prev_s;

  // A coherent Gray source never flips more than one bit between samples.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      prev_s <= init_gray;
      err    <= 1'b0;
    end else begin
      prev_s <= gray_s;
      err    <= err | popcount_gt1(gray_word_t'(gray_s ^ prev_s));
    end
  end
`endif

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Directed bench for gray_sync_decoder at SIZE=4, SYNC_STAGES=2; err checks compile in with GRAY_SYNC_ERRCHK_EN.
module tb_gray_sync_decoder;

  logic       clk = 1'b0;
  logic       nreset;
  logic [3:0] init_count_bin;
  logic [3:0] gray_in;
  logic [3:0] bin_q;
  logic       adv;
  logic [3:0] delta;
`ifdef GRAY_SYNC_ERRCHK_EN
  logic       err;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cur      = 0;

  // 4-bit Gray code, indexed by binary value.
  logic [3:0] G [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                         4'b0110, 4'b0111, 4'b0101, 4'b0100,
                         4'b1100, 4'b1101, 4'b1111, 4'b1110,
                         4'b1010, 4'b1011, 4'b1001, 4'b1000};

  gray_sync_decoder #(
    .SIZE        (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk            (clk),
    .nreset         (nreset),
    .init_count_bin (init_count_bin),
    .gray_in        (gray_in),
    .bin_q          (bin_q),
    .adv            (adv),
    .delta          (delta)
`ifdef GRAY_SYNC_ERRCHK_EN
    ,
    .err            (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_hold(input string tag, input int v);
    chk({tag, "_bin"}, 32'(bin_q), 32'(v));
    chk({tag, "_adv"}, 32'(adv), 0);
    chk({tag, "_delta"}, 32'(delta), 0);
  endtask

  // Drive a new transmitter value, expect it on bin_q on the third edge.
  task automatic apply(input int v, input int d);
    gray_in = G[v];
    tick();
    chk("e1_adv", 32'(adv), 0);
    chk("e1_bin", 32'(bin_q), 32'(cur));
    tick();
    chk("e2_adv", 32'(adv), 0);
    chk("e2_bin", 32'(bin_q), 32'(cur));
    tick();
    chk("e3_bin", 32'(bin_q), 32'(v));
    chk("e3_adv", 32'(adv), 1);
    chk("e3_delta", 32'(delta), 32'(d));
    cur = v;
  endtask

  initial begin
    nreset         = 1'b0;
    init_count_bin = 4'd5;
    gray_in        = 4'b0111;
    tick();
    tick();
    check_hold("rst", 5);
`ifdef GRAY_SYNC_ERRCHK_EN
    chk("rst_err", 32'(err), 0);
`endif
    nreset = 1'b1;
    cur    = 5;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_hold("post_rst", 5);
    end

    // Counting, wrap 15->0, then a coherent 2->5 jump.
    apply(6, 1);
    apply(7, 1);
    apply(8, 1);
    apply(9, 1);
    apply(14, 5);
    apply(15, 1);
    apply(0, 1);
    apply(1, 1);
    apply(2, 1);
    apply(5, 3);
    tick();
    check_hold("hold", 5);
`ifdef GRAY_SYNC_ERRCHK_EN
    chk("jump_err", 32'(err), 0);
`endif

    // Backwards step wraps modulo 16.
    apply(3, 14);

    // Reset while adv is high.
    apply(4, 1);
    nreset         = 1'b0;
    init_count_bin = 4'd5;
    gray_in        = G[5];
    #1;
    check_hold("mid_rst", 5);
    tick();
    tick();
    nreset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_hold("mid_rel", 5);
    end
    cur = 5;

`ifdef GRAY_SYNC_ERRCHK_EN
    nreset         = 1'b0;
    init_count_bin = 4'd0;
    gray_in        = 4'b0000;
    tick();
    chk("err_rst0", 32'(err), 0);
    nreset  = 1'b1;
    gray_in = 4'b0011;
    tick();
    chk("err_e1", 32'(err), 0);
    tick();
    chk("err_e2", 32'(err), 0);
    tick();
    chk("err_e3", 32'(err), 1);
    chk("err_bin", 32'(bin_q), 2);
    chk("err_delta", 32'(delta), 2);
    tick();
    tick();
    chk("err_sticky", 32'(err), 1);
    nreset = 1'b0;
    #1;
    chk("err_clear", 32'(err), 0);
    tick();
    nreset = 1'b1;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
